// File: rtl/rmem_word_fetch.sv
// rmem_word_fetch
// Fetches one 32-bit little-endian word from an arbitrary byte address over a
// word-aligned req/gnt/rvalid data bus. Unaligned addresses take two aligned
// reads whose results are merged so the consumer always sees bytes
// addr..addr+3. Completion is a one-cycle done_o pulse with registered
// rdata_o/err_o.

module rmem_word_fetch #(
    // Cycles to wait for data_rvalid_i after a grant; 0 disables the timeout.
    parameter int unsigned RESP_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    // The counter only has to hold values up to RESP_TIMEOUT-1: the abort is
    // taken on the cycle that would have made it reach RESP_TIMEOUT.
    localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (RESP_TIMEOUT > 0) ? CNT_W'(RESP_TIMEOUT - 1) : '0;
    localparam bit TO_EN = (RESP_TIMEOUT != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        RESP0 = 3'd2,
        REQ1  = 3'd3,
        RESP1 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    // Captured request: word index and byte offset of the start address.
    logic [29:0]       word_reg;
    logic [1:0]        off_reg;

    // First (lower-address) bus word of an unaligned fetch.
    logic [31:0]       lo_reg;

    // Cycles spent waiting for a response in the current RESP state.
    logic [CNT_W-1:0]  cnt_reg;

    // Result registers presented in the DONE cycle and held afterwards.
    logic [31:0]       rdata_reg;
    logic              err_reg;

    // Control strobes from the next-state logic.
    logic              capture;
    logic              lo_load;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              fin_ok;
    logic              fin_err;

    // Merge datapath.
    logic [31:0]       lo_src;
    logic [31:0]       hi_src;
    logic [31:0]       merged;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus the strobes that steer the datapath registers.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        lo_load    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        fin_ok     = 1'b0;
        fin_err    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    capture    = 1'b1;
                    state_next = REQ0;
                end
            end

            REQ0: begin
                if (data_gnt_i) begin
                    cnt_clr    = 1'b1;
                    state_next = RESP0;
                end
            end

            RESP0: begin
                if (data_rvalid_i) begin
                    lo_load = 1'b1;
                    if (data_err_i) begin
                        fin_err    = 1'b1;
                        state_next = DONE;
                    end else if (off_reg == 2'd0) begin
                        fin_ok     = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = REQ1;
                    end
                end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                    fin_err    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            REQ1: begin
                if (data_gnt_i) begin
                    cnt_clr    = 1'b1;
                    state_next = RESP1;
                end
            end

            RESP1: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        fin_err = 1'b1;
                    end else begin
                        fin_ok = 1'b1;
                    end
                    state_next = DONE;
                end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                    fin_err    = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end

            DONE: begin
                // start_i is deliberately not looked at here.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the start address; later addr_i changes are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_reg <= '0;
            off_reg  <= '0;
        end else if (capture) begin
            word_reg <= addr_i[31:2];
            off_reg  <= addr_i[1:0];
        end
    end

    // Hold the first response word for the merge with the second one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_reg <= '0;
        end else if (lo_load) begin
            lo_reg <= data_rdata_i;
        end
    end

    // Response wait counter, restarted on every grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (cnt_clr) begin
            cnt_reg <= '0;
        end else if (cnt_inc) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // The final word arrives on the bus in the same cycle the result is
    // registered, so the high half comes straight from data_rdata_i; the low
    // half is the bus data for an aligned fetch or the held word otherwise.
    always_comb begin
        lo_src = (state_reg == RESP0) ? data_rdata_i : lo_reg;
        hi_src = data_rdata_i;
        merged = lo_src;
        case (off_reg)
            2'd1:    merged = {hi_src[7:0],  lo_src[31:8]};
            2'd2:    merged = {hi_src[15:0], lo_src[31:16]};
            2'd3:    merged = {hi_src[23:0], lo_src[31:24]};
            default: merged = lo_src;
        endcase
    end

    // Result registers load on the edge into DONE, so they are valid together
    // with done_o and keep their value until the next completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (fin_err) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
        end else if (fin_ok) begin
            rdata_reg <= merged;
            err_reg   <= 1'b0;
        end
    end

    // Bus-side and status outputs are pure decodes of registered state, so
    // req and addr stay stable while waiting for a grant.
    always_comb begin
        data_req_o  = 1'b0;
        data_addr_o = '0;
        case (state_reg)
            REQ0: begin
                data_req_o  = 1'b1;
                data_addr_o = {word_reg, 2'b00};
            end
            REQ1: begin
                // Word index wraps naturally at the top of the address space.
                data_req_o  = 1'b1;
                data_addr_o = {word_reg + 30'd1, 2'b00};
            end
            default: begin
                data_req_o  = 1'b0;
                data_addr_o = '0;
            end
        endcase
    end

    assign done_o  = (state_reg == DONE);
    assign busy_o  = (state_reg != IDLE);
    assign rdata_o = rdata_reg;
    assign err_o   = err_reg;

endmodule

// File: tb/tb_rmem_word_fetch.sv
// tb_rmem_word_fetch
// Directed bench: a scripted bus responder, a table of single-read vectors and
// hand-written sequences for grant stall, timeout and mid-transfer reset.

module tb_rmem_word_fetch;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] addr_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        busy_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    always #5 clk = ~clk;

    rmem_word_fetch #(.RESP_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .addr_i       (addr_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .busy_o       (busy_o),
        .data_req_o   (data_req_o),
        .data_addr_o  (data_addr_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_rdata_i (data_rdata_i),
        .data_err_i   (data_err_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus responder ----------------
    int          cfg_gnt_delay;
    int          cfg_rv_delay;
    int          cfg_err_n;      // 1 = first response errors, 2 = second
    bit          cfg_withhold;   // never send rvalid
    logic [31:0] cfg_w0;
    logic [31:0] cfg_w1;
    int          gnt_wait;
    int          rv_wait;
    bit          pend_rv;
    int          resp_idx;
    int          req_n;
    logic [31:0] req_addr [0:3];
    bit          waiting;
    logic [31:0] wait_addr;
    bit          req_unstable;
    int          gnt_cyc;
    bit          manual = 1'b0;

    task automatic bus_cfg(input int gd, input int rd, input int en, input bit wh,
                           input logic [31:0] w0, input logic [31:0] w1);
        cfg_gnt_delay = gd;
        cfg_rv_delay  = rd;
        cfg_err_n     = en;
        cfg_withhold  = wh;
        cfg_w0        = w0;
        cfg_w1        = w1;
        gnt_wait      = gd;
        rv_wait       = 0;
        pend_rv       = 1'b0;
        resp_idx      = 0;
        req_n         = 0;
        waiting       = 1'b0;
        req_unstable  = 1'b0;
        gnt_cyc       = 0;
        for (int i = 0; i < 4; i++) req_addr[i] = '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!manual) begin
                data_gnt_i    = 1'b0;
                data_rvalid_i = 1'b0;
                data_err_i    = 1'b0;
                data_rdata_i  = 32'h0;
                if (pend_rv) begin
                    if (rv_wait == 0) begin
                        data_rvalid_i = 1'b1;
                        data_rdata_i  = (resp_idx == 0) ? cfg_w0 : cfg_w1;
                        data_err_i    = (cfg_err_n == resp_idx + 1);
                        pend_rv       = 1'b0;
                        resp_idx++;
                    end else begin
                        rv_wait--;
                    end
                end else if (data_req_o) begin
                    if (waiting && (data_addr_o != wait_addr)) req_unstable = 1'b1;
                    waiting   = 1'b1;
                    wait_addr = data_addr_o;
                    if (gnt_wait == 0) begin
                        data_gnt_i = 1'b1;
                        if (req_n < 4) req_addr[req_n] = data_addr_o;
                        req_n++;
                        gnt_cyc  = cyc;
                        pend_rv  = !cfg_withhold;
                        rv_wait  = cfg_rv_delay;
                        gnt_wait = cfg_gnt_delay;
                        waiting  = 1'b0;
                    end else begin
                        gnt_wait--;
                    end
                end else if (waiting) begin
                    // Request dropped before it was granted.
                    req_unstable = 1'b1;
                    waiting      = 1'b0;
                end
            end
        end
    end

    // ---------------- done monitor ----------------
    int done_cnt = 0;
    int done_cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then wait (bounded) for done.
    task automatic do_read(input logic [31:0] a, input int budget,
                           output int lat, output bit got);
        int d0;
        int st;
        @(negedge clk);
        d0      = done_cnt;
        st      = cyc;
        start_i = 1'b1;
        addr_i  = a;
        @(negedge clk);
        start_i = 1'b0;
        addr_i  = $urandom;
        got     = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (done_cnt != d0) got = 1'b1;
            else @(negedge clk);
        end
        lat = done_cyc - st;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gnt_d;
        int          rv_d;
        int          err_n;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_nreq;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  got;
        int  d0;
        int  st;

        vecs[0] = '{32'h0000_0100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'hDEADBEEF, 1'b0, 3, 1, 32'h0000_0100, 32'h0};
        vecs[1] = '{32'h0000_0101, 32'h44332211, 32'h88776655, 0, 0, 0, 32'h55443322, 1'b0, 5, 2, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{32'h0000_0103, 32'h44332211, 32'h88776655, 0, 0, 0, 32'h77665544, 1'b0, 5, 2, 32'h0000_0100, 32'h0000_0104};
        vecs[3] = '{32'hFFFF_FFFE, 32'hAABBCCDD, 32'h11223344, 0, 0, 0, 32'h3344AABB, 1'b0, 5, 2, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[4] = '{32'h0000_0102, 32'h44332211, 32'h88776655, 0, 0, 0, 32'h66554433, 1'b0, 5, 2, 32'h0000_0100, 32'h0000_0104};
        vecs[5] = '{32'h0000_0105, 32'h44332211, 32'h88776655, 0, 0, 2, 32'h0000_0000, 1'b1, 5, 2, 32'h0000_0104, 32'h0000_0108};
        vecs[6] = '{32'h0000_0207, 32'h12345678, 32'h9ABCDEF0, 0, 0, 1, 32'h0000_0000, 1'b1, 3, 1, 32'h0000_0204, 32'h0};
        vecs[7] = '{32'h0000_0000, 32'h0F1E2D3C, 32'h0,        0, 0, 0, 32'h0F1E2D3C, 1'b0, 3, 1, 32'h0000_0000, 32'h0};
        vecs[8] = '{32'h0000_0010, 32'h13579BDF, 32'h0,        1, 2, 0, 32'h13579BDF, 1'b0, 6, 1, 32'h0000_0010, 32'h0};

        rst_ni        = 1'b0;
        start_i       = 1'b0;
        addr_i        = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        data_err_i    = 1'b0;
        bus_cfg(0, 0, 0, 1'b0, 32'h0, 32'h0);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy",  32'(busy_o),     32'd0);
        chk("rst_done",  32'(done_o),     32'd0);
        chk("rst_err",   32'(err_o),      32'd0);
        chk("rst_rdata", rdata_o,         32'd0);
        chk("rst_req",   32'(data_req_o), 32'd0);
        chk("rst_addr",  data_addr_o,     32'd0);
        rst_ni = 1'b1;

        // Table of single reads.
        for (int v = 0; v < NV; v++) begin
            bus_cfg(vecs[v].gnt_d, vecs[v].rv_d, vecs[v].err_n, 1'b0, vecs[v].w0, vecs[v].w1);
            do_read(vecs[v].addr, 40, lat, got);
            $display("read %0d addr=0x%08h rdata=0x%08h err=%0b lat=%0d reqs=%0d",
                     v, vecs[v].addr, rdata_o, err_o, lat, req_n);
            chk($sformatf("v%0d_done_seen", v), 32'(got), 32'd1);
            chk($sformatf("v%0d_rdata", v), rdata_o, vecs[v].exp_rdata);
            chk($sformatf("v%0d_err", v), 32'(err_o), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("v%0d_nreq", v), 32'(req_n), 32'(vecs[v].exp_nreq));
            chk($sformatf("v%0d_addr0", v), req_addr[0], vecs[v].exp_a0);
            if (vecs[v].exp_nreq > 1)
                chk($sformatf("v%0d_addr1", v), req_addr[1], vecs[v].exp_a1);
        end

        // Response timeout: rvalid withheld, done five cycles after grant.
        bus_cfg(0, 0, 0, 1'b1, 32'h0, 32'h0);
        do_read(32'h0000_0300, 40, lat, got);
        $display("read timeout addr=0x00000300 rdata=0x%08h err=%0b grant_to_done=%0d",
                 rdata_o, err_o, done_cyc - gnt_cyc);
        chk("to_done_seen", 32'(got), 32'd1);
        chk("to_err", 32'(err_o), 32'd1);
        chk("to_rdata", rdata_o, 32'd0);
        chk("to_grant_to_done", 32'(done_cyc - gnt_cyc), 32'd5);

        // Grant stall of five cycles with an extra start pulse while busy.
        bus_cfg(5, 0, 0, 1'b0, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        d0      = done_cnt;
        st      = cyc;
        start_i = 1'b1;
        addr_i  = 32'h0000_0100;
        @(negedge clk);
        start_i = 1'b0;
        addr_i  = 32'h0;
        @(negedge clk);
        chk("stall_busy", 32'(busy_o), 32'd1);
        chk("stall_req", 32'(data_req_o), 32'd1);
        chk("stall_addr", data_addr_o, 32'h0000_0100);
        start_i = 1'b1;
        addr_i  = 32'h0000_0200;
        @(negedge clk);
        start_i = 1'b0;
        addr_i  = 32'h0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (done_cnt != d0) got = 1'b1;
            else @(negedge clk);
        end
        $display("read stall addr=0x00000100 rdata=0x%08h err=%0b lat=%0d",
                 rdata_o, err_o, done_cyc - st);
        chk("stall_done_seen", 32'(got), 32'd1);
        chk("stall_rdata", rdata_o, 32'hDEADBEEF);
        chk("stall_latency", 32'(done_cyc - st), 32'd8);
        repeat (6) @(negedge clk);
        chk("stall_done_count", 32'(done_cnt - d0), 32'd1);
        chk("stall_nreq", 32'(req_n), 32'd1);
        chk("stall_req_addr", req_addr[0], 32'h0000_0100);
        chk("stall_req_stable", 32'(req_unstable), 32'd0);

        // Reset while waiting in RESP0, then a stray response.
        bus_cfg(0, 0, 0, 1'b1, 32'h55AA55AA, 32'h0);
        @(negedge clk);
        start_i = 1'b1;
        addr_i  = 32'h0000_0400;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy_o), 32'd1);
        chk("mid_req_in_resp", 32'(data_req_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        chk("mrst_busy",  32'(busy_o),     32'd0);
        chk("mrst_done",  32'(done_o),     32'd0);
        chk("mrst_rdata", rdata_o,         32'd0);
        chk("mrst_err",   32'(err_o),      32'd0);
        chk("mrst_req",   32'(data_req_o), 32'd0);
        chk("mrst_addr",  data_addr_o,     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        d0     = done_cnt;
        manual        = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFEF00D;
        data_err_i    = 1'b1;
        @(negedge clk);
        data_rvalid_i = 1'b0;
        data_rdata_i  = 32'h0;
        data_err_i    = 1'b0;
        manual        = 1'b0;
        repeat (4) @(negedge clk);
        $display("stray rvalid after reset: busy=%0b rdata=0x%08h err=%0b",
                 busy_o, rdata_o, err_o);
        chk("stray_no_done", 32'(done_cnt - d0), 32'd0);
        chk("stray_busy", 32'(busy_o), 32'd0);
        chk("stray_rdata", rdata_o, 32'd0);
        chk("stray_err", 32'(err_o), 32'd0);

        // Fresh aligned read after the reset.
        bus_cfg(0, 0, 0, 1'b0, 32'hA5A50F0F, 32'h0);
        do_read(32'h0000_0400, 40, lat, got);
        $display("read fresh addr=0x00000400 rdata=0x%08h err=%0b lat=%0d",
                 rdata_o, err_o, lat);
        chk("fresh_done_seen", 32'(got), 32'd1);
        chk("fresh_rdata", rdata_o, 32'hA5A50F0F);
        chk("fresh_err", 32'(err_o), 32'd0);
        chk("fresh_latency", 32'(lat), 32'd3);
        chk("fresh_addr", req_addr[0], 32'h0000_0400);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
